my_stream_trigger: RTL

Trigger and decimation stage that sits directly upstream of the sample-storage block. It accepts a raw two-channel ADC stream, keeps every (DECIM+1)-th sample, and watches a selected channel for a level crossing. On a crossing it opens a gate and forwards kept samples on an Avalon-ST source, whose data/valid pair feeds the storage block's asi_in0 sink. It is configured and disarmed over a small Avalon-MM slave.

---
 rtl/my_stream_trigger.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/my_stream_trigger.sv
// Decimating level trigger ahead of sample storage: keeps every (DECIM+1)-th sample and gates them
// onto an Avalon-ST source after a crossing or FORCE. Auto-trigger exists only with MY_STREAM_TRIGGER_AUTO_EN.
module my_stream_trigger #(
   parameter int unsigned AUTO_TIMEOUT = 4096
) (
   input  logic        csi_clk,
   input  logic        rsi_reset_n,
   input  logic [1:0]  avs_s0_address,
   input  logic        avs_s0_read,
   output logic [31:0] avs_s0_readdata,
   input  logic        avs_s0_write,
   input  logic [31:0] avs_s0_writedata,
   input  logic [31:0] asi_in0_data,
   input  logic        asi_in0_valid,
   output logic [31:0] aso_out0_data,
   output logic        aso_out0_valid,
   output logic        coe_triggered
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_TRIG  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic               arm_q, slope_q, ch_q;
   logic [15:0]        level_q, decim_q;
   logic [15:0]        dec_cnt_q, dec_cnt_d;
   logic               kept_q;
   logic [31:0]        sample_q;
   logic signed [15:0] prev_q, prev_d;
   logic               prev_valid_q, prev_valid_d;
   logic [31:0]        out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               triggered_q;
   logic               auto_fired_q, auto_fired_d;
   logic [15:0]        trig_cnt_q, trig_cnt_d;
   logic               ctrl_wr_s, level_wr_s, decim_wr_s;
   logic               arm_eff_s, force_s, keep_s;
   logic signed [15:0] cur_s, level_s;
   logic               rise_s, fall_s, cross_s, auto_hit_s;
   logic               unused_s;

   assign ctrl_wr_s  = avs_s0_write && (avs_s0_address == 2'd0);
   assign level_wr_s = avs_s0_write && (avs_s0_address == 2'd1);
   assign decim_wr_s = avs_s0_write && (avs_s0_address == 2'd2);
   // A CTRL write acts in the cycle it is sampled, so a disarm kills the very next output beat.
   assign arm_eff_s  = ctrl_wr_s ? avs_s0_writedata[0] : arm_q;
   assign force_s    = ctrl_wr_s && avs_s0_writedata[1];
   assign keep_s     = asi_in0_valid && (state_q != ST_IDLE) && (dec_cnt_q == 16'd0);
   assign unused_s   = ^{avs_s0_read, avs_s0_writedata[31:16]};

   assign level_s = $signed(level_q);
   assign cur_s   = ch_q ? $signed(sample_q[31:16]) : $signed(sample_q[15:0]);
   assign rise_s  = (prev_q < level_s) && (cur_s >= level_s);
   assign fall_s  = (prev_q > level_s) && (cur_s <= level_s);
   assign cross_s = (state_q == ST_ARMED) && kept_q && prev_valid_q && (slope_q ? fall_s : rise_s);

`ifdef MY_STREAM_TRIGGER_AUTO_EN
   localparam logic [15:0] AUTO_LIMIT = 16'(AUTO_TIMEOUT);
   logic [15:0] to_cnt_q, to_cnt_d;

   always_comb begin
      to_cnt_d = to_cnt_q;
      if (state_q != ST_ARMED) begin
         to_cnt_d = 16'd0;
      end else if (kept_q) begin
         to_cnt_d = to_cnt_q + 16'd1;
      end else begin
         to_cnt_d = to_cnt_q;
      end
   end

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         to_cnt_q <= 16'd0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end

   assign auto_hit_s = (state_q == ST_ARMED) && kept_q && ((to_cnt_q + 16'd1) == AUTO_LIMIT);
`else
   logic unused_auto_s;
   assign unused_auto_s = ^AUTO_TIMEOUT;
   assign auto_hit_s    = 1'b0;
`endif

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         arm_q   <= 1'b0;
         slope_q <= 1'b0;
         ch_q    <= 1'b0;
         level_q <= 16'd0;
         decim_q <= 16'd0;
      end else begin
         if (ctrl_wr_s) begin
            arm_q   <= avs_s0_writedata[0];
            slope_q <= avs_s0_writedata[2];
            ch_q    <= avs_s0_writedata[3];
         end
         if (level_wr_s) begin
            level_q <= avs_s0_writedata[15:0];
         end
         if (decim_wr_s) begin
            decim_q <= avs_s0_writedata[15:0];
         end
      end
   end

   always_comb begin
      dec_cnt_d = dec_cnt_q;
      if ((state_q == ST_IDLE) || decim_wr_s) begin
         dec_cnt_d = 16'd0;
      end else if (asi_in0_valid) begin
         dec_cnt_d = (dec_cnt_q >= decim_q) ? 16'd0 : (dec_cnt_q + 16'd1);
      end else begin
         dec_cnt_d = dec_cnt_q;
      end
   end

   always_comb begin
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      if (state_q != ST_ARMED) begin
         prev_valid_d = 1'b0;
      end else if (kept_q) begin
         prev_d       = cur_s;
         prev_valid_d = 1'b1;
      end else begin
         prev_valid_d = prev_valid_q;
      end
   end

   // Disarm outranks every trigger source; a crossing forwards its own sample, FORCE/auto do not.
   always_comb begin
      state_d      = state_q;
      out_valid_d  = 1'b0;
      out_data_d   = out_data_q;
      auto_fired_d = auto_fired_q;
      trig_cnt_d   = trig_cnt_q;
      if (!arm_eff_s) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_ARMED;
            ST_ARMED: state_d = (cross_s || force_s || auto_hit_s) ? ST_TRIG : ST_ARMED;
            ST_TRIG:  state_d = ST_TRIG;
            default:  state_d = ST_IDLE;
         endcase
      end
      out_valid_d = (state_d == ST_TRIG) && kept_q && ((state_q == ST_TRIG) || cross_s);
      if (out_valid_d) begin
         out_data_d = sample_q;
      end else begin
         out_data_d = out_data_q;
      end
      if (state_d != ST_TRIG) begin
         auto_fired_d = 1'b0;
         trig_cnt_d   = 16'd0;
      end else begin
         if ((state_q == ST_ARMED) && auto_hit_s && !cross_s && !force_s) begin
            auto_fired_d = 1'b1;
         end else begin
            auto_fired_d = auto_fired_q;
         end
         if (out_valid_d && (trig_cnt_q != 16'hFFFF)) begin
            trig_cnt_d = trig_cnt_q + 16'd1;
         end else begin
            trig_cnt_d = trig_cnt_q;
         end
      end
   end

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         state_q      <= ST_IDLE;
         dec_cnt_q    <= 16'd0;
         kept_q       <= 1'b0;
         sample_q     <= 32'd0;
         prev_q       <= 16'sd0;
         prev_valid_q <= 1'b0;
         out_data_q   <= 32'd0;
         out_valid_q  <= 1'b0;
         triggered_q  <= 1'b0;
         auto_fired_q <= 1'b0;
         trig_cnt_q   <= 16'd0;
      end else begin
         state_q      <= state_d;
         dec_cnt_q    <= dec_cnt_d;
         kept_q       <= keep_s;
         if (keep_s) begin
            sample_q <= asi_in0_data;
         end
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         triggered_q  <= (state_d == ST_TRIG);
         auto_fired_q <= auto_fired_d;
         trig_cnt_q   <= trig_cnt_d;
      end
   end

   always_comb begin
      avs_s0_readdata = 32'd0;
      case (avs_s0_address)
         2'd0:    avs_s0_readdata = {28'd0, ch_q, slope_q, 1'b0, arm_q};
         2'd1:    avs_s0_readdata = {16'd0, level_q};
         2'd2:    avs_s0_readdata = {16'd0, decim_q};
         2'd3:    avs_s0_readdata = {trig_cnt_q, 13'd0, auto_fired_q, state_q};
         default: avs_s0_readdata = 32'd0;
      endcase
   end

   assign aso_out0_data  = out_data_q;
   assign aso_out0_valid = out_valid_q;
   assign coe_triggered  = triggered_q;

endmodule
